// File: rtl/ssram_ctrl.sv
// Bus target for a 1M x 32 flow-through synchronous SSRAM. The transaction timing
// is locked to the bus sequencer's idle/start/pre/post sequence. Every output is registered.
module ssram_ctrl #(
    parameter int         ADDR_WIDTH = 20,
    parameter logic [3:0] CS_ID      = 4'h6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [3:0]            chipselect,
    input  logic                  read,
    input  logic                  write,
    input  logic [31:0]           address,
    input  logic [3:0]            be,
    input  logic [31:0]           data_in,
    output logic [31:0]           data_out,
    output logic                  ready,
    output logic [ADDR_WIDTH-1:0] ssram_addr,
    output logic [31:0]           ssram_dq_out,
    input  logic [31:0]           ssram_dq_in,
    output logic                  ssram_dq_oe,
    output logic                  ssram_ce_n,
    output logic                  ssram_adsc_n,
    output logic                  ssram_we_n,
    output logic [3:0]            ssram_be_n,
    output logic                  ssram_oe_n
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  is_write_q, is_write_d;
    logic [31:0]           data_out_q, data_out_d;
    logic                  ready_q, ready_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           dq_out_q, dq_out_d;
    logic                  dq_oe_q, dq_oe_d;
    logic                  ce_n_q, ce_n_d;
    logic                  adsc_n_q, adsc_n_d;
    logic                  we_n_q, we_n_d;
    logic [3:0]            be_n_q, be_n_d;
    logic                  oe_n_q, oe_n_d;
    logic                  accept_s;
    logic                  unused_addr_s;

    assign unused_addr_s = ^{address[31:ADDR_WIDTH+2], address[1:0]};
    assign accept_s      = start && (chipselect == CS_ID) && (read || write);

    // Next state and next pin values; pins are computed one cycle ahead so they register cleanly.
    always_comb begin
        state_d    = state_q;
        is_write_d = is_write_q;
        data_out_d = data_out_q;
        ready_d    = 1'b0;
        addr_d     = addr_q;
        dq_out_d   = dq_out_q;
        dq_oe_d    = 1'b0;
        ce_n_d     = 1'b1;
        adsc_n_d   = 1'b1;
        we_n_d     = 1'b1;
        be_n_d     = 4'hf;
        oe_n_d     = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d    = S_ADDR;
                    is_write_d = write;
                    addr_d     = address[ADDR_WIDTH+1:2];
                    ce_n_d     = 1'b0;
                    adsc_n_d   = 1'b0;
                    if (write) begin
                        we_n_d   = 1'b0;
                        be_n_d   = ~be;
                        dq_oe_d  = 1'b1;
                        dq_out_d = data_in;
                    end else begin
                        oe_n_d = 1'b0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ADDR: begin
                state_d = S_DATA;
                if (is_write_q) begin
                    dq_oe_d = 1'b1;
                end else begin
                    oe_n_d = 1'b0;
                end
            end
            S_DATA: begin
                // Flow-through read data is valid during this cycle.
                state_d = S_HOLD;
                ready_d = 1'b1;
                if (!is_write_q) begin
                    data_out_d = ssram_dq_in;
                end else begin
                    data_out_d = data_out_q;
                end
            end
            S_HOLD: begin
                if (read || write) begin
                    state_d = S_HOLD;
                    ready_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            is_write_q <= 1'b0;
            data_out_q <= 32'h0;
            ready_q    <= 1'b0;
            addr_q     <= '0;
            dq_out_q   <= 32'h0;
            dq_oe_q    <= 1'b0;
            ce_n_q     <= 1'b1;
            adsc_n_q   <= 1'b1;
            we_n_q     <= 1'b1;
            be_n_q     <= 4'hf;
            oe_n_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            is_write_q <= is_write_d;
            data_out_q <= data_out_d;
            ready_q    <= ready_d;
            addr_q     <= addr_d;
            dq_out_q   <= dq_out_d;
            dq_oe_q    <= dq_oe_d;
            ce_n_q     <= ce_n_d;
            adsc_n_q   <= adsc_n_d;
            we_n_q     <= we_n_d;
            be_n_q     <= be_n_d;
            oe_n_q     <= oe_n_d;
        end
    end

    assign data_out     = data_out_q;
    assign ready        = ready_q;
    assign ssram_addr   = addr_q;
    assign ssram_dq_out = dq_out_q;
    assign ssram_dq_oe  = dq_oe_q;
    assign ssram_ce_n   = ce_n_q;
    assign ssram_adsc_n = adsc_n_q;
    assign ssram_we_n   = we_n_q;
    assign ssram_be_n   = be_n_q;
    assign ssram_oe_n   = oe_n_q;

endmodule

// File: tb/tb_ssram_ctrl.sv
// Directed self-checking bench for ssram_ctrl with a small flow-through SSRAM model.
module tb_ssram_ctrl;

    logic        clock = 1'b0;
    logic        reset, start, read, write;
    logic [3:0]  chipselect, be;
    logic [31:0] address, data_in, data_out;
    logic        ready;
    logic [19:0] ssram_addr;
    logic [31:0] ssram_dq_out, ssram_dq_in;
    logic        ssram_dq_oe, ssram_ce_n, ssram_adsc_n, ssram_we_n, ssram_oe_n;
    logic [3:0]  ssram_be_n;

    int n_cmp = 0;
    int n_err = 0;
    int overlap_cnt = 0;
    logic [31:0] mem [logic [19:0]];

    ssram_ctrl #(.ADDR_WIDTH(20), .CS_ID(4'h6)) dut (
        .clock(clock), .reset(reset), .start(start), .chipselect(chipselect),
        .read(read), .write(write), .address(address), .be(be), .data_in(data_in),
        .data_out(data_out), .ready(ready), .ssram_addr(ssram_addr),
        .ssram_dq_out(ssram_dq_out), .ssram_dq_in(ssram_dq_in), .ssram_dq_oe(ssram_dq_oe),
        .ssram_ce_n(ssram_ce_n), .ssram_adsc_n(ssram_adsc_n), .ssram_we_n(ssram_we_n),
        .ssram_be_n(ssram_be_n), .ssram_oe_n(ssram_oe_n)
    );

    always #5 clock = ~clock;

    // Flow-through SSRAM: samples on ADSC, read data appears in the following cycle.
    initial ssram_dq_in = 32'hBAD0BAD0;
    always @(posedge clock) begin
        if (!ssram_ce_n && !ssram_adsc_n) begin
            if (!ssram_we_n) begin
                logic [31:0] w;
                w = mem.exists(ssram_addr) ? mem[ssram_addr] : 32'h0;
                for (int b = 0; b < 4; b++)
                    if (!ssram_be_n[b]) w[b*8 +: 8] = ssram_dq_out[b*8 +: 8];
                mem[ssram_addr] = w;
                ssram_dq_in <= 32'hBAD0BAD0;
            end else begin
                ssram_dq_in <= mem.exists(ssram_addr) ? mem[ssram_addr] : 32'h0;
            end
        end else begin
            ssram_dq_in <= 32'hBAD0BAD0;
        end
    end

    always @(negedge clock) if (ssram_dq_oe && !ssram_oe_n) overlap_cnt++;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        tick(); tick();
        n_cmp++; if (data_out !== 32'h0) begin n_err++; $display("FAIL rst_data_out act=%h exp=%h", data_out, 32'h0); end
        n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL rst_ready act=%b exp=0", ready); end
        n_cmp++; if ({ssram_ce_n, ssram_adsc_n, ssram_we_n, ssram_oe_n} !== 4'b1111) begin n_err++; $display("FAIL rst_strobes act=%b exp=1111", {ssram_ce_n, ssram_adsc_n, ssram_we_n, ssram_oe_n}); end
        n_cmp++; if (ssram_be_n !== 4'hf) begin n_err++; $display("FAIL rst_be_n act=%h exp=f", ssram_be_n); end
        n_cmp++; if ({ssram_dq_oe, ssram_addr, ssram_dq_out} !== 53'h0) begin n_err++; $display("FAIL rst_dq_addr act=%b/%h/%h exp=0", ssram_dq_oe, ssram_addr, ssram_dq_out); end
        reset = 1'b0; tick();
        // write aborted by reset during S_DATA
        chipselect = 4'h6; write = 1'b1; address = 32'h0000_0400; be = 4'hf; data_in = 32'h0000_0055; start = 1'b1;
        tick(); start = 1'b0;
        n_cmp++; if (ssram_we_n !== 1'b0) begin n_err++; $display("FAIL abort_t1_we_n act=%b exp=0", ssram_we_n); end
        tick();
        n_cmp++; if (ssram_dq_oe !== 1'b1) begin n_err++; $display("FAIL abort_t2_dq_oe act=%b exp=1", ssram_dq_oe); end
        reset = 1'b1; tick(); tick(); reset = 1'b0; write = 1'b0;
        n_cmp++; if ({ssram_we_n, ssram_dq_oe, ssram_ce_n, ready} !== 4'b1010) begin n_err++; $display("FAIL abort_pins act=%b exp=1010", {ssram_we_n, ssram_dq_oe, ssram_ce_n, ready}); end
        n_cmp++; if ({data_out, ssram_dq_out} !== 64'h0) begin n_err++; $display("FAIL abort_data act=%h/%h exp=0", data_out, ssram_dq_out); end
        tick();
        n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL abort_idle_ready act=%b exp=0", ready); end
    endtask

    task automatic test_write();
        chipselect = 4'h6; write = 1'b1; read = 1'b0; address = 32'h0000_4008; be = 4'b0011; data_in = 32'hDEADBEEF; start = 1'b1;
        tick(); start = 1'b0;
        n_cmp++; if (ssram_addr !== 20'h01002) begin n_err++; $display("FAIL wr_addr act=%h exp=01002", ssram_addr); end
        n_cmp++; if ({ssram_ce_n, ssram_adsc_n, ssram_we_n, ssram_oe_n, ssram_dq_oe} !== 5'b00011) begin n_err++; $display("FAIL wr_t1_strobes act=%b exp=00011", {ssram_ce_n, ssram_adsc_n, ssram_we_n, ssram_oe_n, ssram_dq_oe}); end
        n_cmp++; if (ssram_be_n !== 4'b1100) begin n_err++; $display("FAIL wr_be_n act=%b exp=1100", ssram_be_n); end
        n_cmp++; if (ssram_dq_out !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_dq_out act=%h exp=deadbeef", ssram_dq_out); end
        tick();
        n_cmp++; if ({ssram_we_n, ssram_adsc_n, ssram_dq_oe, ready} !== 4'b1110) begin n_err++; $display("FAIL wr_t2 act=%b exp=1110", {ssram_we_n, ssram_adsc_n, ssram_dq_oe, ready}); end
        tick();
        n_cmp++; if ({ready, ssram_dq_oe} !== 2'b10) begin n_err++; $display("FAIL wr_t3 act=%b exp=10", {ready, ssram_dq_oe}); end
        n_cmp++; if (data_out !== 32'h0) begin n_err++; $display("FAIL wr_data_out_kept act=%h exp=0", data_out); end
        write = 1'b0; tick();
        n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL wr_ready_drop act=%b exp=0", ready); end
        n_cmp++; if (mem[20'h01002] !== 32'h0000BEEF) begin n_err++; $display("FAIL wr_mem act=%h exp=0000beef", mem[20'h01002]); end
    endtask

    task automatic test_read();
        mem[20'h01002] = 32'h12345678;
        chipselect = 4'h6; read = 1'b1; address = 32'h0000_4008; start = 1'b1;
        tick(); start = 1'b0;
        n_cmp++; if ({ssram_oe_n, ssram_we_n, ssram_dq_oe} !== 3'b010) begin n_err++; $display("FAIL rd_t1 act=%b exp=010", {ssram_oe_n, ssram_we_n, ssram_dq_oe}); end
        n_cmp++; if ({ssram_addr, ssram_be_n} !== {20'h01002, 4'hf}) begin n_err++; $display("FAIL rd_t1_addr act=%h/%h exp=01002/f", ssram_addr, ssram_be_n); end
        tick();
        n_cmp++; if (ssram_oe_n !== 1'b0) begin n_err++; $display("FAIL rd_t2_oe_n act=%b exp=0", ssram_oe_n); end
        tick();
        n_cmp++; if ({ready, data_out} !== {1'b1, 32'h12345678}) begin n_err++; $display("FAIL rd_t3 act=%b/%h exp=1/12345678", ready, data_out); end
        tick();
        n_cmp++; if ({ready, data_out} !== {1'b1, 32'h12345678}) begin n_err++; $display("FAIL rd_t4_hold act=%b/%h exp=1/12345678", ready, data_out); end
        read = 1'b0; tick();
        n_cmp++; if ({ready, data_out} !== {1'b0, 32'h12345678}) begin n_err++; $display("FAIL rd_release act=%b/%h exp=0/12345678", ready, data_out); end
    endtask

    task automatic test_wrong_cs();
        chipselect = 4'h5; read = 1'b1; address = 32'h0000_0008; start = 1'b1;
        tick(); start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({ssram_ce_n, ssram_adsc_n, ssram_we_n, ssram_oe_n, ssram_dq_oe, ready} !== 6'b111100) begin
                n_err++; $display("FAIL wrong_cs cycle=%0d act=%b exp=111100", i, {ssram_ce_n, ssram_adsc_n, ssram_we_n, ssram_oe_n, ssram_dq_oe, ready});
            end
            tick();
        end
        read = 1'b0; chipselect = 4'h6; tick();
    endtask

    task automatic test_back_to_back();
        mem[20'h00010] = 32'h12345678;
        write = 1'b1; address = 32'h0000_0040; be = 4'b1010; data_in = 32'hAABBCCDD; start = 1'b1;
        tick(); start = 1'b0; tick(); tick();
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL b2b_wr_ready act=%b exp=1", ready); end
        write = 1'b0; tick();
        read = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        n_cmp++; if (ssram_oe_n !== 1'b0) begin n_err++; $display("FAIL b2b_rd_accept act=%b exp=0", ssram_oe_n); end
        tick(); tick();
        n_cmp++; if ({ready, data_out} !== {1'b1, 32'hAA34CC78}) begin n_err++; $display("FAIL b2b_rd_data act=%b/%h exp=1/aa34cc78", ready, data_out); end
        read = 1'b0; tick();
        n_cmp++; if (overlap_cnt !== 0) begin n_err++; $display("FAIL oe_overlap act=%0d exp=0", overlap_cnt); end
    endtask

    task automatic test_early_drop();
        mem[20'h00020] = 32'hCAFEF00D;
        read = 1'b1; address = 32'h0000_0080; start = 1'b1;
        tick(); start = 1'b0; read = 1'b0; tick(); tick();
        n_cmp++; if ({ready, data_out} !== {1'b1, 32'hCAFEF00D}) begin n_err++; $display("FAIL drop_t3 act=%b/%h exp=1/cafef00d", ready, data_out); end
        tick();
        n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL drop_t4_ready act=%b exp=0", ready); end
        read = 1'b1; address = 32'h0000_4008; start = 1'b1;
        tick(); start = 1'b0; read = 1'b0;
        n_cmp++; if ({ssram_oe_n, ssram_adsc_n} !== 2'b00) begin n_err++; $display("FAIL drop_reaccept act=%b exp=00", {ssram_oe_n, ssram_adsc_n}); end
        tick(); tick();
        n_cmp++; if ({ready, data_out} !== {1'b1, 32'h12345678}) begin n_err++; $display("FAIL drop_second act=%b/%h exp=1/12345678", ready, data_out); end
        tick();
    endtask

    task automatic test_simultaneous();
        read = 1'b1; write = 1'b1; address = 32'h0000_000C; be = 4'hf; data_in = 32'h0BADCAFE; start = 1'b1;
        tick(); start = 1'b0;
        n_cmp++; if ({ssram_we_n, ssram_dq_oe, ssram_oe_n} !== 3'b011) begin n_err++; $display("FAIL both_t1 act=%b exp=011", {ssram_we_n, ssram_dq_oe, ssram_oe_n}); end
        tick(); tick();
        n_cmp++; if ({ready, data_out} !== {1'b1, 32'h12345678}) begin n_err++; $display("FAIL both_t3 act=%b/%h exp=1/12345678", ready, data_out); end
        read = 1'b0; write = 1'b0; tick();
        n_cmp++; if (mem[20'h00003] !== 32'h0BADCAFE) begin n_err++; $display("FAIL both_mem act=%h exp=0badcafe", mem[20'h00003]); end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; read = 1'b0; write = 1'b0;
        chipselect = 4'h0; be = 4'h0; address = 32'h0; data_in = 32'h0;
        test_reset();
        test_write();
        test_read();
        test_wrong_cs();
        test_back_to_back();
        test_early_drop();
        test_simultaneous();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ssram_ctrl.md
# ssram_ctrl

Bus target for the external 1M x 32 synchronous flow-through SSRAM, sitting on the CPU memory bus opposite the address decoder/bus sequencer. It accepts one transaction per decoder `start` pulse when `chipselect` selects it, drives the SSRAM control, address and data pins, and returns read data on a registered bus. Its cycle timing is locked to the sequencer's fixed four-state sequence: idle, start (address latch), pre (access), post (data visible, wait released).

## Interface
- `ADDR_WIDTH`, 20: SSRAM word-address width; uses bus `address[ADDR_WIDTH+1:2]`.
- `CS_ID`, 4'h6: `chipselect` code that selects this target.
- `clock` in 1: single clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle transaction start from the bus sequencer.
- `chipselect` in 4: decoded region code.
- `read` in 1: bus read request, held through the transaction.
- `write` in 1: bus write request, held through the transaction.
- `address` in 32: byte address.
- `be` in 4: byte enables, active high; `be[0]` = bits 7:0.
- `data_in` in 32: write data from the master.
- `data_out` out 32: registered read data.
- `ready` out 1: high while `data_out` is valid, or while a write is complete.
- `ssram_addr` out ADDR_WIDTH: SSRAM word address.
- `ssram_dq_out` out 32: SSRAM write data.
- `ssram_dq_in` in 32: SSRAM read data.
- `ssram_dq_oe` out 1: tristate enable for `ssram_dq_out`.
- `ssram_ce_n` out 1: chip enable, active low.
- `ssram_adsc_n` out 1: address strobe, active low.
- `ssram_we_n` out 1: write enable, active low.
- `ssram_be_n` out 4: byte write enables, active low.
- `ssram_oe_n` out 1: SSRAM output enable, active low.

## Operation
- Accept condition is `start && chipselect == CS_ID && (read || write)` while the state is S_IDLE. On accept, register the following:
  - word address `address[ADDR_WIDTH+1:2]`;
  - `is_write = write`; `write` wins if `read` and `write` are both high;
  - `be` and `data_in`.
- `address[1:0]` and the bits above `ADDR_WIDTH+1` are ignored.
- States:
  - S_IDLE: all SSRAM strobes inactive. On accept, go to S_ADDR.
  - S_ADDR: drive `ssram_ce_n=0` and `ssram_adsc_n=0`, and drive `ssram_addr` from the register.
    - Write: `ssram_we_n=0`, `ssram_be_n=~be_reg`, `ssram_dq_oe=1`.
    - Read: `ssram_we_n=1`, `ssram_be_n=4'hf`, `ssram_oe_n=0`.
    - Always go to S_DATA.
  - S_DATA:
    - Read: keep `ssram_oe_n=0` and capture `ssram_dq_in` into `data_out` at the end of the cycle.
    - Write: keep `ssram_dq_oe=1` for data hold; `ssram_we_n` and `ssram_adsc_n` return high.
    - Go to S_HOLD.
  - S_HOLD: `ready=1`, all SSRAM strobes inactive, `ssram_dq_oe=0`, `data_out` stable. Stay while `read || write`; go to S_IDLE when both are low.
- `start` in any state other than S_IDLE is ignored; the protocol forbids it.
- `start` with a non-matching `chipselect` is ignored and produces no pin activity.
- `data_out` keeps the last read value until the next read capture. A write does not alter it.

## Timing
- Reset values (applied at the first rising edge with `reset=1`):
  - state S_IDLE, `data_out=0`, `ready=0`, `ssram_addr=0`, `ssram_dq_out=0`, `ssram_dq_oe=0`;
  - `ssram_ce_n=1`, `ssram_adsc_n=1`, `ssram_we_n=1`, `ssram_be_n=4'hf`, `ssram_oe_n=1`.
- All outputs are registered. There is no combinational path from bus inputs to SSRAM pins.
- Cycle T0 is the accept cycle (sequencer start state). Then:
  - T1 = S_ADDR: pins active; the SSRAM samples at the end of T1.
  - T2 = S_DATA: read data is captured at the end of T2.
  - T3 onward = S_HOLD: `ready=1`, read data valid.
- Read latency from accept to `ready` and valid `data_out` is 3 cycles.
- Write: `ssram_we_n` is low for exactly one cycle (T1). `ssram_dq_oe` is high for T1 and T2 only.
- `ssram_dq_oe` and `ssram_oe_n=0` are never both active in the same cycle.
- Back-to-back transactions: the minimum re-accept is the cycle after S_HOLD exits to S_IDLE. The sequencer's idle cycle guarantees bus turnaround.
- `reset` mid-transaction (any state): the state goes to S_IDLE and all outputs take their reset values at that edge. Any in-flight write is abandoned with `ssram_we_n` high from that edge.
- If `read`/`write` drop during S_ADDR or S_DATA, the access still completes. S_HOLD is passed through for one cycle, then the state goes to S_IDLE.

## Test plan
- **Reset:** assert `reset` for 2 cycles during S_DATA of a write → next cycle `ssram_we_n=1`, `ssram_dq_oe=0`, `ssram_ce_n=1`, `ready=0`, `data_out=0`.
- **Write:** `start`, `chipselect=6`, `write=1`, `address=32'h0000_4008`, `be=4'b0011`, `data_in=32'hDEADBEEF` →
  - T1: `ssram_addr=20'h01002`, `ssram_we_n=0`, `ssram_be_n=4'b1100`, `ssram_dq_out=32'hDEADBEEF`;
  - T3: `ready=1`.
- **Read:** model returns `32'h12345678` at word `20'h01002` → T1 has `ssram_oe_n=0`, `ssram_we_n=1`; at T3 `data_out=32'h12345678` and `ready=1`, held until `read` drops, then `ready=0` one cycle later.
- **Wrong chipselect:** `start` with `chipselect=4'h5` and `read=1` → no pin activity and `ready` stays 0 for 5 cycles.
- **Back-to-back:** write then read at the same address with the sequencer's idle gap → read returns the written bytes. `ssram_dq_oe` and `ssram_oe_n` never overlap.
- **Early drop and simultaneous requests:**
  - `read` dropped in T1 → `ready` pulses for exactly one cycle at T3, then the state returns to S_IDLE;
  - `read=write=1` → treated as a write.
